// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side interface of the oversampling UART receiver.
// The receiver drives it through the master modport; the RX FIFO or
// debug unit consumes it through the slave modport.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 frame_error;
    logic                 parity_error;

    modport master (
        output rx_data,
        output rx_done,
        output rx_busy,
        output frame_error,
        output parity_error
    );

    modport slave (
        input rx_data,
        input rx_done,
        input rx_busy,
        input frame_error,
        input parity_error
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (LSB first, start/data/stop framing).
// The serial line is sampled on baud_tick strobes; the start bit is
// qualified at its middle, every following bit is sampled one bit period
// later, and the stop bit is checked STOP_TICKS strobes after the last
// data (or parity) sample. Each frame is delivered with a one-clk rx_done.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between
// the data and the stop phase (PARITY_ODD selects odd parity). Without the
// macro parity_error is tied low and no parity state or flops exist.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      baud_tick,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0]    TICK_ZERO    = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0]    TICK_ONE     = TICK_W'(1);
    localparam logic [TICK_W-1:0]    START_MID    = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0]    BIT_LAST     = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0]    STOP_LAST    = TICK_W'(STOP_TICKS - 1);
    localparam logic [BIT_W-1:0]     BIT_ZERO     = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]     BIT_ONE      = BIT_W'(1);
    localparam logic [BIT_W-1:0]     BIT_CNT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] WORD_ZERO    = {DATA_BITS{1'b0}};

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Received word, received parity bit and the configured sense combine
    // into a single mismatch flag.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] word,
                                             input logic                 pbit);
        return (^word) ^ pbit ^ PARITY_ODD;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    state_t               state_r,    state_s;
    logic [TICK_W-1:0]    tick_cnt_r, tick_cnt_s;
    logic [BIT_W-1:0]     bit_cnt_r,  bit_cnt_s;
    logic [DATA_BITS-1:0] shift_r,    shift_s;
    logic [DATA_BITS-1:0] data_r,     data_s;
    logic                 done_r,     done_s;
    logic                 ferr_r,     ferr_s;
    logic                 busy_r;
`ifdef UART_RX_PARITY_EN
    logic                 pbit_r,     pbit_s;
    logic                 perr_r,     perr_s;
`endif

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state, counter, shift and output-update logic of the frame FSM.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        data_s     = data_r;
        done_s     = 1'b0;
        ferr_s     = ferr_r;
`ifdef UART_RX_PARITY_EN
        pbit_s     = pbit_r;
        perr_s     = perr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // Falling edge seen: start timing from here, ticks ignored in IDLE.
                if (!rx_sync_r) begin
                    state_s    = ST_START;
                    tick_cnt_s = TICK_ZERO;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tick_cnt_r == START_MID) begin
                        tick_cnt_s = TICK_ZERO;
                        // Still low at mid start bit: genuine frame, else a glitch.
                        if (!rx_sync_r) begin
                            state_s   = ST_DATA;
                            bit_cnt_s = BIT_ZERO;
                        end else begin
                            state_s   = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_r == BIT_LAST) begin
                        shift_s    = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        tick_cnt_s = TICK_ZERO;
                        bit_cnt_s  = bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == BIT_CNT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_s = ST_PARITY;
`else
                            state_s = ST_STOP;
`endif
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt_r == BIT_LAST) begin
                        pbit_s     = rx_sync_r;
                        tick_cnt_s = TICK_ZERO;
                        state_s    = ST_STOP;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_r == STOP_LAST) begin
                        // Frame is handed over even when the stop bit is bad.
                        data_s     = shift_r;
                        ferr_s     = ~rx_sync_r;
                        done_s     = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_s     = parity_mismatch(shift_r, pbit_r);
`endif
                        tick_cnt_s = TICK_ZERO;
                        state_s    = ST_IDLE;
                    end else begin
                        tick_cnt_s = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            default: begin
                // Unreachable encodings fall back to a clean idle.
                state_s    = ST_IDLE;
                tick_cnt_s = TICK_ZERO;
                bit_cnt_s  = BIT_ZERO;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= WORD_ZERO;
            data_r     <= WORD_ZERO;
            done_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_r     <= 1'b0;
            perr_r     <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            data_r     <= data_s;
            done_r     <= done_s;
            ferr_r     <= ferr_s;
            // Lags the state by one clk so busy covers the rx_done cycle.
            busy_r     <= (state_r != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            pbit_r     <= pbit_s;
            perr_r     <= perr_s;
`endif
        end
    end

    assign bus.rx_data     = data_r;
    assign bus.rx_done     = done_r;
    assign bus.rx_busy     = busy_r;
    assign bus.frame_error = ferr_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error = perr_r;
`else
    assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx.
// Frames are built bit by bit on the serial line; each frame that should
// complete pushes its expected word and error flags into a queue, and a
// monitor pops that queue on every rx_done pulse.
module tb_uart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int STOP_TICKS = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
    localparam bit PARITY_ODD = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic baud_tick = 1'b0;
    logic rx        = 1'b1;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         n_done    = 0;
    int         n_exp     = 0;
    logic [7:0] last_data = 8'h00;
    logic       chk_fall  = 1'b0;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .STOP_TICKS(STOP_TICKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_tick(baud_tick),
        .rx       (rx),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Baud strobe: one clk high every TICK_DIV clks, changed on the falling edge.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            baud_tick = (c == TICK_DIV - 1);
            c = (c + 1) % TICK_DIV;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold_line(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    function automatic logic exp_perr(input logic [7:0] d, input logic pbit);
`ifdef UART_RX_PARITY_EN
        return (^d) ^ pbit ^ PARITY_ODD;
`else
        return 1'b0 & (^d) & pbit;
`endif
    endfunction

    // One frame: start, LSB-first data, optional parity, stop, idle gap.
    // rst_bit >= 0 pulses reset during that data bit and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic pbit,
                              input int rst_bit, input int gap_bits);
        exp_t x;
        if (rst_bit < 0) begin
            x.data = d;
            x.ferr = ~stop_ok;
            x.perr = exp_perr(d, pbit);
            exp_q.push_back(x);
            n_exp++;
        end
        hold_line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rx = d[i];
                repeat (16) @(negedge clk);
                check("busy_mid_frame", 32'(bus.rx_busy), 32'd1);
                reset = 1'b0;
                #1;
                check("rst_rx_data", 32'(bus.rx_data), 32'd0);
                check("rst_rx_done", 32'(bus.rx_done), 32'd0);
                check("rst_rx_busy", 32'(bus.rx_busy), 32'd0);
                check("rst_frame_error", 32'(bus.frame_error), 32'd0);
                check("rst_parity_error", 32'(bus.parity_error), 32'd0);
                last_data = 8'h00;
                repeat (2) @(negedge clk);
                reset = 1'b1;
                repeat (BIT_CLKS - 18) @(negedge clk);
            end else begin
                hold_line(d[i], BIT_CLKS);
            end
        end
`ifdef UART_RX_PARITY_EN
        hold_line(pbit, BIT_CLKS);
`endif
        if (stop_ok) begin
            hold_line(1'b1, BIT_CLKS);
        end else begin
            // Low through the stop sample point, then idle long enough for
            // the receiver to reject the trailing low as a false start.
            hold_line(1'b0, (BIT_CLKS * 3) / 4);
            hold_line(1'b1, BIT_CLKS / 4 + BIT_CLKS);
        end
        hold_line(1'b1, gap_bits * BIT_CLKS);
        if (rst_bit < 0) begin
            last_data = d;
        end
        check("done_count", 32'(n_done), 32'(n_exp));
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (chk_fall) begin
                        check("busy_fall_after_done", 32'(bus.rx_busy), 32'd0);
                        chk_fall = 1'b0;
                    end
                    if (bus.rx_done) begin
                        n_done++;
                        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("rx_data", 32'(bus.rx_data), 32'(e.data));
                            check("frame_error", 32'(bus.frame_error), 32'(e.ferr));
                            check("parity_error", 32'(bus.parity_error), 32'(e.perr));
                            check("busy_in_done", 32'(bus.rx_busy), 32'd1);
                        end
                        chk_fall = 1'b1;
                    end
                end
            end
            begin : stimulus
                logic [7:0] d;
                logic       ok;
                logic       pb;
                repeat (3) @(negedge clk);
                check("reset_rx_data", 32'(bus.rx_data), 32'd0);
                check("reset_rx_done", 32'(bus.rx_done), 32'd0);
                check("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
                check("reset_frame_error", 32'(bus.frame_error), 32'd0);
                check("reset_parity_error", 32'(bus.parity_error), 32'd0);
                reset = 1'b1;
                hold_line(1'b1, 2 * BIT_CLKS);

                // Nominal, framing error followed by a clean frame.
                send_frame(8'hA5, 1'b1, 1'b0, -1, 1);
                send_frame(8'h3C, 1'b0, 1'b0, -1, 0);
                send_frame(8'h55, 1'b1, 1'b0, -1, 1);

                // Start glitch of three ticks.
                rx = 1'b0;
                repeat (3 * TICK_DIV) @(negedge clk);
                check("busy_during_glitch", 32'(bus.rx_busy), 32'd1);
                rx = 1'b1;
                repeat ((OVERSAMPLE / 2) * TICK_DIV + 8) @(negedge clk);
                check("glitch_busy_cleared", 32'(bus.rx_busy), 32'd0);
                check("glitch_data_held", 32'(bus.rx_data), 32'(last_data));
                check("glitch_no_done", 32'(n_done), 32'(n_exp));
                hold_line(1'b1, BIT_CLKS);

                // Back-to-back frames with no idle between them.
                send_frame(8'h00, 1'b1, 1'b0, -1, 0);
                send_frame(8'hFF, 1'b1, 1'b0, -1, 0);
                send_frame(8'h81, 1'b1, 1'b0, -1, 1);

                // Reset during data bit 4, then a normal frame.
                send_frame(8'hF0, 1'b1, 1'b0, 4, 1);
                check("after_reset_data", 32'(bus.rx_data), 32'd0);
                send_frame(8'h12, 1'b1, 1'b0, -1, 1);

                // Parity good / bad (parity_error stays low without the feature).
                send_frame(8'h07, 1'b1, 1'b1, -1, 1);
                send_frame(8'h07, 1'b1, 1'b0, -1, 1);

                // Randomized frames, gaps and stop-bit corruption.
                for (int i = 0; i < 12; i++) begin
                    d  = 8'($urandom_range(0, 255));
                    ok = ($urandom_range(0, 4) != 0);
                    pb = 1'($urandom_range(0, 1));
                    send_frame(d, ok, pb, -1, $urandom_range(0, 2));
                end

                for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
                    @(negedge clk);
                end
                check("queue_drained", 32'(exp_q.size()), 32'd0);
                check("final_done_count", 32'(n_done), 32'(n_exp));
            end
        join_any
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver; the consumer of the baud-rate generator's tick.
- Samples the serial line on each baud_tick (OVERSAMPLE ticks per bit) and recovers 8N1-style frames, LSB first.
- Delivers each byte with a one-cycle done pulse to the downstream RX FIFO / debug-unit interface.
- Sits between the pin-level rx input and the datapath-facing byte interface.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.
- STOP_TICKS, 16, baud_tick pulses for the stop phase, counted from mid-last-bit; 16 = 1 stop bit, 32 = 2 stop bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- baud_tick  input  1  one-clk-wide oversample strobe from the baud-rate generator.
- rx  input  1  serial line, idle high; asynchronous to clk.
- rx_data  output  DATA_BITS  last received word; held until the next rx_done.
- rx_done  output  1  one-clk pulse; rx_data and error flags are valid in that cycle.
- rx_busy  output  1  high whenever the FSM is not in IDLE.
- frame_error  output  1  stop bit was sampled low in the last frame; updated with rx_done.
- parity_error  output  1  parity mismatch in the last frame (see Optional Feature); updated with rx_done.

Behaviour:
- Synchroniser: rx passes through 2 flops (rx_sync); both reset to 1. This adds 2 clk of input latency.
- Reset (reset=0, async): state=IDLE, tick_cnt=0, bit_cnt=0, shift=0.
  - Outputs: rx_data=0, rx_done=0, rx_busy=0, frame_error=0, parity_error=0.
  - Reset mid-frame abandons the frame; no rx_done is issued.
- Counters: tick_cnt is ceil(log2(max(OVERSAMPLE,STOP_TICKS))) bits. bit_cnt is ceil(log2(DATA_BITS+1)) bits. Counters advance only on clk edges where baud_tick=1.
- IDLE:
  - When rx_sync=0: go to START, tick_cnt=0.
  - Otherwise stay in IDLE. baud_tick is ignored.
- START: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
  - If rx_sync=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - If rx_sync=1: treat as a glitch; return to IDLE with no output change.
- DATA: on the tick where tick_cnt==OVERSAMPLE-1 (mid bit):
  - shift = {rx_sync, shift[DATA_BITS-1:1]} (LSB first); tick_cnt=0; bit_cnt++.
  - After DATA_BITS samples: go to PARITY if the feature is enabled, else STOP.
- STOP: on the tick where tick_cnt==STOP_TICKS-1:
  - rx_data<=shift; frame_error<=~rx_sync; rx_done pulses for exactly 1 clk; go to IDLE.
  - The frame is delivered even when frame_error=1.
- Back-to-back frames: IDLE detects the next start edge on the first clk after STOP exits. No dead time is required.
- rx_busy is registered from the state: 1 from the clk after leaving IDLE through the rx_done cycle.
- The last rx_done timing gives at most 1/2 stop bit of margin before the next start edge. rx_done never coincides with a new start-bit decision.
- baud_tick held high continuously is legal and simply advances at the clk rate.
- A baud_tick that coincides with the asynchronous reset is lost.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0) is added.
  - The FSM gains a PARITY state between DATA and STOP. The parity bit is sampled on tick_cnt==OVERSAMPLE-1, then tick_cnt=0 and the FSM goes to STOP.
  - parity_error<=(^shift ^ parity_bit ^ PARITY_ODD) is registered and updated in the rx_done cycle.
- When not defined:
  - There is no PARITY state and no extra flops.
  - parity_error is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- Nominal frame: OVERSAMPLE=16, baud_tick every 4 clk. Drive 0xA5 as 8N1 → exactly one rx_done pulse; rx_data=0xA5; frame_error=0; rx_busy falls in the clk after rx_done.
- Framing error: drive 0x3C with the stop bit held low → rx_done pulses; rx_data=0x3C; frame_error=1. A following valid 0x55 frame → rx_data=0x55, frame_error=0.
- Start glitch: pull rx low for 3 ticks, then high → no rx_done; rx_busy returns to 0 within OVERSAMPLE/2 ticks; rx_data keeps its previous value.
- Back-to-back: frames 0x00, 0xFF, 0x81 with zero idle between them → three rx_done pulses in order with those values, and no frame_error.
- Reset mid-frame: assert reset=0 for 2 clk during data bit 4 of 0xF0 → all outputs read 0 immediately (asynchronously); no rx_done. A following 0x12 frame is received correctly.
- Parity (UART_RX_PARITY_EN, PARITY_ODD=0): 0x07 with parity bit 1 → parity_error=0. The same data with parity bit 0 → parity_error=1. Without the macro, parity_error stays 0.
